// File: rtl/clarvi_button_pio.sv
// Avalon-MM input PIO for buttons and switches: synchroniser, per-bit debounce,
// sticky edge capture and a maskable level interrupt.
module clarvi_button_pio #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrRsvd = 2'd1;
    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  stable_dly_q;
    logic [WIDTH-1:0]                  rise, fall, evt;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  edge_q, edge_d;
    logic [WIDTH-1:0]                  edge_clr;
    logic [31:0]                       readdata_q, readdata_d;
    logic                              wr_mask, wr_edge;

    // Synchroniser chain; stage 0 samples the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
        assign stable_d = sync;
    end else begin : g_debounce
        localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

        logic [CntW-1:0] cnt_q [WIDTH];
        logic [CntW-1:0] cnt_d [WIDTH];

        // A differing level must survive DEBOUNCE_CYCLES consecutive cycles; any
        // return to the stable level restarts the count. >= keeps it saturating.
        always_comb begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_d[i]    = '0;
                stable_d[i] = stable_q[i];
                if (sync[i] != stable_q[i]) begin
                    if (cnt_q[i] >= CntLast) begin
                        stable_d[i] = sync[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign rise = stable_q & ~stable_dly_q;
    assign fall = ~stable_q & stable_dly_q;

    always_comb begin
        evt = rise;
        if (EDGE_TYPE == 1) begin
            evt = fall;
        end else if (EDGE_TYPE == 2) begin
            evt = rise | fall;
        end
    end

    assign wr_mask = write && (address == AddrMask);
    assign wr_edge = write && (address == AddrEdge);

    // A new event on a bit outranks a same-cycle write-1-clear of that bit.
    always_comb begin
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_mask) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_edge) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~edge_clr) | evt;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            AddrData: readdata_d = 32'(stable_q);
            AddrRsvd: readdata_d = '0;
            AddrMask: readdata_d = 32'(mask_q);
            AddrEdge: readdata_d = 32'(edge_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

endmodule

// File: doc/clarvi_button_pio.md
Name: clarvi_button_pio

Overview:
Parametrised Avalon-MM input PIO for push-buttons and switches. Each input passes through a synchroniser and a per-bit debouncer, then edge detection with sticky capture and a maskable interrupt. It sits on the clarvi_soc peripheral bus and replaces the plain read-only input port, which has no synchronisation, debounce, edge capture or IRQ.

Parameters:
WIDTH, 16, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (2..4)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles needed to accept a new level; 0 = debounce bypassed
EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
address  input  2  Avalon word address
write  input  1  Avalon write strobe, active-high
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
in_port  input  WIDTH  raw asynchronous button/switch inputs
irq  output  1  level interrupt, active-high

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. On reset, all sync flops, stable[], debounce counters, irq_mask, edge_capture and readdata clear to 0, and irq = 0.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit produces sync[WIDTH-1:0].
- Debouncer, per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync != stable, the counter increments. When the counter == DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and the counter clears.
  - If sync == stable, the counter clears.
  - Net effect: a new level must persist DEBOUNCE_CYCLES consecutive cycles to be accepted, and a glitch restarts the count.
  - With DEBOUNCE_CYCLES = 0, stable <= sync every cycle.
  - The counter saturates and never wraps.
- Edge detect: stable_d is stable delayed by one cycle. Per-bit event conditions:
  - Rising: stable & ~stable_d.
  - Falling: ~stable & stable_d.
  - Any: the XOR of the two.
- edge_capture[i] sets on event[i] and stays set until cleared by software.
- Register map. Write latency 0: the register updates on the clk edge where write = 1.
  - Address 0, DATA: reads stable zero-extended to 32 bits. Writes are ignored.
  - Address 1: reads 0. Writes are ignored.
  - Address 2, IRQ_MASK: read/write of bits [WIDTH-1:0]. Upper bits read 0.
  - Address 3, EDGE_CAPTURE: reads the capture bits. Writing 1 to bit i clears it; writing 0 has no effect.
- Read: readdata <= mux(address) every clk, with no read strobe. Read latency is 1 cycle. Bits at or above WIDTH always read 0.
- irq = |(edge_capture & irq_mask), driven combinationally from registers. irq asserts the cycle after the capture bit sets and deasserts the cycle after the clear or mask write.
- Simultaneous events:
  - If an event and a write-1-clear hit the same bit in the same cycle, the set wins and the bit remains 1.
  - A clear of other bits proceeds normally.
- Latency from in_port change to DATA visible, with a clean input: SYNC_STAGES + DEBOUNCE_CYCLES cycles to stable, plus 1 for readdata.
- Inputs high at reset: stable starts at 0 and goes to 1 after debounce. This produces a rising event, which is required behaviour. Software clears EDGE_CAPTURE after init.
- Reset mid-operation: all state is lost immediately and no pending edge survives. The counters restart from 0 after deassertion.

Test Plan:
1. Reset state, WIDTH = 16, DEBOUNCE_CYCLES = 4: assert reset_n = 0 with in_port = 0 -> readdata = 0, irq = 0. Read addresses 0..3 after release -> all 0x00000000.
2. Clean press:
   - Stimulus: in_port = 0x0001 held 10 cycles, then read address 0.
   - Response: stable[0] rises exactly 2 + 4 cycles after the change, and readdata = 0x00000001 one cycle after the read address.
3. Glitch rejection: pulse in_port[3] high for 3 cycles, then low -> DATA stays 0x0000 and EDGE_CAPTURE stays 0. Hold it for 4+ cycles -> DATA = 0x0008.
4. IRQ flow, EDGE_TYPE = 0:
   - Stimulus: write IRQ_MASK = 0x0003, then press bit 1.
   - Response: EDGE_CAPTURE = 0x0002 and irq = 1.
   - Write 0x0002 to address 3 -> irq = 0 next cycle. Write 0x0000 to address 3 -> no change.
5. Set-beats-clear: schedule the bit-0 rising event in the same cycle as a write of 0x0001 to address 3 -> EDGE_CAPTURE[0] = 1 and irq remains asserted.
6. Width/mode sweep, WIDTH = 5, EDGE_TYPE = 2, DEBOUNCE_CYCLES = 0:
   - Toggle in_port[4] 1 -> 0 -> EDGE_CAPTURE = 0x10 on both edges.
   - Write IRQ_MASK = 0xFFFFFFFF -> reads back 0x0000001F.
   - Reset mid-debounce -> all registers 0.
